// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller:
// segment bit positions and the hex-digit glyph table.
package sevenseg_pkg;

    typedef enum int {
        SEG_A  = 0,
        SEG_B  = 1,
        SEG_C  = 2,
        SEG_D  = 3,
        SEG_E  = 4,
        SEG_F  = 5,
        SEG_G  = 6,
        SEG_DP = 7
    } seg_pos_e;

    // Glyphs are active-high, bit SEG_A in bit 0 through SEG_G in bit 6.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph (active-high, a..g).
module sevenseg_hex_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg[SEG_G:SEG_A] = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment controller: per-digit pattern store with masked
// raw/hex writes, time-multiplexed digit scan and per-slot PWM brightness.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int SUB_DIV        = 8192,
    parameter int DIM_BITS       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_port,
    input  logic                  mode,
    input  logic [8*N_DIGITS-1:0] val,
    input  logic [8*N_DIGITS-1:0] mask,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic                  done_port,
    output logic [7:0]            sseg_ca,
    output logic [N_DIGITS-1:0]   sseg_an
);

    localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

    // XOR masks that turn active-high internal levels into pin polarity.
    localparam logic [7:0]          CA_POL = {8{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] AN_POL = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [8*N_DIGITS-1:0] mem;
    logic [8*N_DIGITS-1:0] pattern;
    logic [SUB_W-1:0]      sub_cnt;
    logic [DIM_BITS-1:0]   phase;
    logic [DIM_BITS-1:0]   bright_q;
    logic [N_DIGITS-1:0]   index;
    logic                  sub_wrap;
    logic                  slot_wrap;
    logic                  slot_start;
    logic                  en;
    logic [7:0]            active_byte;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        logic [6:0] glyph;

        sevenseg_hex_decoder u_hex_decoder (
            .nibble (val[8*i +: 4]),
            .seg    (glyph)
        );

        assign pattern[8*i +: 8] = mode ? {val[8*i + SEG_DP], glyph} : val[8*i +: 8];
    end

    // NOTE: the pattern store is a plain flop vector, so clearing it on
    // reset is cheap and guarantees a blank display after power-up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem       <= '0;
            done_port <= 1'b0;
        end else begin
            if (start_port) begin
                mem <= (mem & ~mask) | (pattern & mask);
            end
            done_port <= start_port;
        end
    end

    assign sub_wrap   = (sub_cnt == SUB_W'(SUB_DIV - 1));
    assign slot_wrap  = sub_wrap && (phase == '1);
    assign slot_start = (sub_cnt == '0) && (phase == '0);
    assign en         = (phase < bright_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sub_cnt  <= '0;
            phase    <= '0;
            bright_q <= '0;
            index    <= N_DIGITS'(1);
        end else begin
            sub_cnt <= sub_wrap ? '0 : sub_cnt + SUB_W'(1);
            if (sub_wrap) begin
                phase <= phase + DIM_BITS'(1);
            end
            if (slot_start) begin
                bright_q <= brightness;
            end
            // Rotate-left expression also degenerates correctly for one digit.
            if (slot_wrap) begin
                index <= (index << 1) | (index >> (N_DIGITS - 1));
            end
        end
    end

    always_comb begin
        active_byte = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (index[i]) begin
                active_byte = active_byte | mem[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sseg_ca <= CA_POL;
            sseg_an <= AN_POL;
        end else begin
            sseg_ca <= (en ? active_byte : 8'h00) ^ CA_POL;
            sseg_an <= (en ? index : '0) ^ AN_POL;
        end
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for the pong board-level wrapper.
- Stores one 8-bit segment pattern per digit. Patterns are written either as raw segment bits or as hex nibbles that the block decodes.
- Scans the digits in time and applies per-display PWM brightness.
- Everything runs in the single `clock` domain. A prescaler produces enable ticks, so no clock is derived from a counter bit.
- Driven from an HLS-generated accelerator through the start_port/done_port handshake.

Parameters:
N_DIGITS, 8, number of digits/anodes (1..16)
SUB_DIV, 8192, clock cycles per PWM sub-phase (>=1)
DIM_BITS, 4, brightness resolution; a slot is 2^DIM_BITS sub-phases long
SEG_ACTIVE_LOW, 1, 1 = sseg_ca driven low to light a segment
AN_ACTIVE_LOW, 1, 1 = sseg_an driven low to enable a digit

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
start_port  in  1  one-cycle write strobe
mode  in  1  0 = raw segment bits, 1 = hex decode; sampled with start_port
val  in  8*N_DIGITS  per-digit byte; hex mode: [3:0] nibble, [7] decimal point
mask  in  8*N_DIGITS  per-bit write enable
brightness  in  DIM_BITS  PWM duty, sampled at every slot start
done_port  out  1  one-cycle pulse acknowledging a write
sseg_ca  out  8  segment drive for the current digit (bit0=a .. bit6=g, bit7=dp)
sseg_an  out  N_DIGITS  anode drive, at most one active

Behaviour:
- Internal store mem[8*N_DIGITS-1:0] is active-high (1 = segment lit).
- Write: when start_port=1 at a posedge, each digit i forms a pattern p_i.
  - Raw mode: p_i = val[8i+7:8i].
  - Hex mode: p_i = {val[8i+7], hexdec(val[8i+3:0])}.
  - Update rule: mem <= (mem & ~mask) | (p & mask).
  - done_port = 1 in the following cycle only.
- Back-to-back start_port: every strobe is applied and acknowledged; done_port stays high one cycle per strobe.
- Hex table (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Prescaler:
  - sub_cnt counts 0..SUB_DIV-1. On wrap, phase (DIM_BITS wide) increments.
  - When phase wraps from all-ones to 0, the one-hot index rotates left: digit i -> i+1, digit N_DIGITS-1 -> 0.
  - N_DIGITS=1: index stays at digit 0.
- brightness is latched into bright_q when phase=0 and sub_cnt=0. A mid-slot change takes effect at the next slot.
- Digit enable: en = (phase < bright_q).
  - brightness=0: display dark.
  - All-ones: (2^DIM_BITS-1)/2^DIM_BITS duty.
- Outputs are registered, 1 cycle after the internal state.
  - sseg_an = index when en, else all inactive; inverted if AN_ACTIVE_LOW.
  - sseg_ca = mem byte of the active digit when en, else 0; inverted if SEG_ACTIVE_LOW.
- Write-to-display latency: 2 cycles, i.e. mem updates at +1, pins reflect it at +2 if that digit is scanned.
- A write coinciding with an index rotation is not lost. The new digit shows the new mem value one cycle later.
- Reset (asynchronous, active-low), taking effect immediately and also mid-slot:
  - mem = 0, index = digit 0, sub_cnt = 0, phase = 0, bright_q = 0.
  - done_port = 0.
  - sseg_ca and sseg_an at inactive levels (0xFF / all ones for the active-low defaults).
- Scanning restarts from digit 0 after release.
- Strobes asserted while in reset are ignored.

Decomposition:
- Package sevenseg_pkg: segment bit-position constants (SEG_A..SEG_DP), the 16-entry hex-to-segment constant table, and a function hex_to_seg.
- One sub-module, sevenseg_hex_decoder: combinational nibble -> 7 segments, instantiated N_DIGITS times via generate.
- Prescaler, scan and PWM logic stay in the top module.

Test Plan:
Bench configuration for all scenarios: N_DIGITS=8, SUB_DIV=4, DIM_BITS=2, active-low outputs; slot = 16 cycles.
1. Reset: hold reset=0 for 3 cycles -> sseg_ca=8'hFF, sseg_an=8'hFF, done_port=0. Assert reset mid-slot -> both outputs return to 0xFF within the cycle.
2. Hex write: mode=1, mask=all ones, val=64'h83, brightness=3 -> done_port high exactly 1 cycle. While sseg_an=8'hFE, sseg_ca=8'h30 (pattern CF inverted); digits 1..7 show sseg_ca=8'hFF.
3. Masked raw write: after scenario 2, mode=0, mask=64'hFF00, val=64'h3F00 -> digit 1 shows sseg_ca=8'hC0, digit 0 still 8'h30.
4. PWM: brightness=1 -> the active digit's anode is enabled 4 of every 16 cycles. brightness=0 -> sseg_an stays 8'hFF. A change mid-slot only applies from the next slot boundary.
5. Scan order: free-run 128 cycles -> sseg_an active bit walks FE, FD, FB ... 7F and returns to FE at cycle 128.
6. Back-to-back: start_port high on 3 consecutive cycles with different val -> three done_port pulses; the final mem equals the third write.
